// File: rtl/tqvp_rebeccargb_intercal_select.sv
// INTERCAL select (~) and unmingle engine for the TinyQV peripheral bus.
// Both operations walk VALUE one bit per cycle for 32 cycles.
module tqvp_rebeccargb_intercal_select (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready
);

  localparam logic [5:0] AddrValueLo = 6'h00;
  localparam logic [5:0] AddrValueHi = 6'h02;
  localparam logic [5:0] AddrMaskLo  = 6'h04;
  localparam logic [5:0] AddrMaskHi  = 6'h06;
  localparam logic [5:0] AddrCtrl    = 6'h08;
  localparam logic [5:0] AddrResLo   = 6'h0C;
  localparam logic [5:0] AddrResHi   = 6'h0E;

  localparam logic [1:0] Width16   = 2'b01;
  localparam logic [1:0] Width32   = 2'b10;
  localparam logic [1:0] WidthNone = 2'b11;

  logic [31:0] value_q, value_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] vsh_q, vsh_d;
  logic [31:0] msh_q, msh_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  idx_q, idx_d;
  // Pack index and popcount are the same quantity during SELECT.
  logic [5:0]  pop_q, pop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mode_q, mode_d;

  logic wr16, wr32, wr_any, rd16, rd32, rd_any;
  logic res_addr, res_read_ok;
  logic unused_ui;

  assign unused_ui = ^ui_in;
  assign uo_out    = 8'h00;

  assign wr16   = (data_write_n == Width16);
  assign wr32   = (data_write_n == Width32);
  assign wr_any = (data_write_n != WidthNone);
  assign rd16   = (data_read_n == Width16);
  assign rd32   = (data_read_n == Width32);
  assign rd_any = (data_read_n != WidthNone);

  assign res_addr    = (address == AddrResLo) || (address == AddrResHi);
  assign data_ready  = !(busy_q && rd_any && res_addr);
  assign res_read_ok = rd_any && (((address == AddrResLo) && (rd16 || rd32)) ||
                                  ((address == AddrResHi) && rd16));

  always_comb begin
    value_d  = value_q;
    mask_d   = mask_q;
    vsh_d    = vsh_q;
    msh_d    = msh_q;
    result_d = result_q;
    idx_d    = idx_q;
    pop_d    = pop_q;
    busy_d   = busy_q;
    done_d   = done_q;
    mode_d   = mode_q;

    if (busy_q) begin
      if (mode_q) begin
        // Even bits fill the low half, odd bits the high half.
        result_d[{idx_q[0], idx_q[4:1]}] = vsh_q[0];
      end else if (msh_q[0]) begin
        result_d[pop_q[4:0]] = vsh_q[0];
        pop_d                = pop_q + 6'd1;
      end
      vsh_d = vsh_q >> 1;
      msh_d = msh_q >> 1;
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else begin
      if (res_read_ok) done_d = 1'b0;

      if ((address == AddrValueLo) && wr32) value_d = data_in;
      else if ((address == AddrValueLo) && wr16) value_d[15:0] = data_in[15:0];
      else if ((address == AddrValueHi) && wr16) value_d[31:16] = data_in[15:0];

      if ((address == AddrMaskLo) && wr32) mask_d = data_in;
      else if ((address == AddrMaskLo) && wr16) mask_d[15:0] = data_in[15:0];
      else if ((address == AddrMaskHi) && wr16) mask_d[31:16] = data_in[15:0];

      if ((address == AddrCtrl) && wr_any && (data_in[0] || data_in[1])) begin
        vsh_d    = value_q;
        msh_d    = mask_q;
        result_d = 32'h0;
        idx_d    = 5'd0;
        pop_d    = 6'd0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        mode_d   = !data_in[0];
      end
    end
  end

  always_comb begin
    data_out = 32'h0;
    if (data_ready && rd_any) begin
      case (address)
        AddrCtrl:  data_out = {18'h0, pop_q, 5'h0, mode_q, done_q, busy_q};
        AddrResLo: begin
          if (rd32)      data_out = result_q;
          else if (rd16) data_out = {16'h0, result_q[15:0]};
        end
        AddrResHi: if (rd16) data_out = {16'h0, result_q[31:16]};
        default:   data_out = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= 32'h0;
      mask_q   <= 32'h0;
      vsh_q    <= 32'h0;
      msh_q    <= 32'h0;
      result_q <= 32'h0;
      idx_q    <= 5'd0;
      pop_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      value_q  <= value_d;
      mask_q   <= mask_d;
      vsh_q    <= vsh_d;
      msh_q    <= msh_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      pop_q    <= pop_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: tb/tb_tqvp_rebeccargb_intercal_select.sv
// Randomized self-checking bench for the INTERCAL select/unmingle engine.
module tb_tqvp_rebeccargb_intercal_select;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tqvp_rebeccargb_intercal_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ui_in        (ui_in),
    .uo_out       (uo_out),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_select(input logic [31:0] v, input logic [31:0] m);
    logic [31:0] r = 32'h0;
    int k = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        r[k] = v[i];
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_unmingle(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i]      = v[2*i];
      r[16 + i] = v[2*i + 1];
    end
    return r;
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    address = a; data_in = d; data_write_n = w;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, input logic [1:0] w,
                    output logic [31:0] d, output logic r);
    address = a; data_read_n = w;
    #1;
    d = data_out;
    r = data_ready;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic set_vm(input logic [31:0] v, input logic [31:0] m, input bit half);
    if (half) begin
      wr(6'h00, {16'h0, v[15:0]}, 2'b01);
      wr(6'h02, {16'h0, v[31:16]}, 2'b01);
      wr(6'h04, {16'h0, m[15:0]}, 2'b01);
      wr(6'h06, {16'h0, m[31:16]}, 2'b01);
    end else begin
      wr(6'h00, v, 2'b10);
      wr(6'h04, m, 2'b10);
    end
  endtask

  task automatic start(input logic mode);
    logic [1:0] w;
    w = 2'($urandom_range(0, 2));
    wr(6'h08, mode ? 32'h2 : 32'h1, w);
  endtask

  // Counts falling edges seen with busy=1, bounded.
  task automatic wait_idle(output int n);
    logic [31:0] d;
    logic r;
    n = 0;
    rd(6'h08, 2'b10, d, r);
    while (d[0] && n < 40) begin
      n++;
      rd(6'h08, 2'b10, d, r);
    end
  endtask

  task automatic verify(input string tag, input logic mode, input logic [31:0] er,
                        input logic [5:0] ep);
    logic [31:0] d;
    logic r;
    rd(6'h08, 2'b10, d, r);
    check_eq({tag, " status"}, d, {18'h0, ep, 5'h0, mode, 1'b1, 1'b0});
    rd(6'h0C, 2'b10, d, r);
    check_eq({tag, " result"}, d, er);
    check_eq({tag, " ready"}, {31'h0, r}, 32'h1);
    rd(6'h0C, 2'b01, d, r);
    check_eq({tag, " lo16"}, d, {16'h0, er[15:0]});
    rd(6'h0E, 2'b01, d, r);
    check_eq({tag, " hi16"}, d, {16'h0, er[31:16]});
    rd(6'h08, 2'b10, d, r);
    check_eq({tag, " done clr"}, d, {18'h0, ep, 5'h0, mode, 1'b0, 1'b0});
  endtask

  task automatic run_op(input string tag, input logic mode, input logic [31:0] v,
                        input logic [31:0] m, input bit half);
    int n;
    logic [31:0] er;
    set_vm(v, m, half);
    start(mode);
    wait_idle(n);
    check_eq({tag, " busy cycles"}, n, 32);
    er = mode ? ref_unmingle(v) : ref_select(v, m);
    verify(tag, mode, er, mode ? 6'd0 : 6'($countones(m)));
  endtask

  initial begin
    logic [31:0] d, leak, v, m;
    logic r;
    int n;

    // Reset state
    @(negedge clk);
    address = 6'h08; data_read_n = 2'b10;
    #1;
    check_eq("reset status", data_out, 32'h0);
    check_eq("reset uo_out", {24'h0, uo_out}, 32'h0);
    address = 6'h0C;
    #1;
    check_eq("reset ready", {31'h0, data_ready}, 32'h1);
    data_read_n = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sel1", 1'b0, 32'h12345678, 32'hF0F0F0F0, 1'b0);
    run_op("sel2", 1'b0, 32'hDEADBEEF, 32'h0000FFFF, 1'b0);
    run_op("unm1", 1'b1, 32'hAAAAAAAA, 32'h0, 1'b0);
    run_op("unm2", 1'b1, 32'h0000FFFF, 32'h0, 1'b0);
    run_op("mask0", 1'b0, 32'h87654321, 32'h0, 1'b0);
    run_op("mask1", 1'b0, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);
    run_op("half", 1'b0, 32'h12345678, 32'hF0F0F0F0, 1'b1);

    rd(6'h0C, 2'b00, d, r);
    check_eq("rd8 result", d, 32'h0);

    // Read held from a few cycles into the operation
    set_vm(32'h0F1E2D3C, 32'h33CC55AA, 1'b0);
    start(1'b0);
    repeat (4) @(negedge clk);
    address = 6'h0C; data_read_n = 2'b10;
    n = 0; leak = 32'h0;
    #1;
    while (!data_ready && n < 40) begin
      n++;
      leak |= data_out;
      @(negedge clk);
      #1;
    end
    check_eq("stall cycles", n, 28);
    check_eq("stall data zero", leak, 32'h0);
    check_eq("stall result", data_out, ref_select(32'h0F1E2D3C, 32'h33CC55AA));
    @(negedge clk);
    data_read_n = 2'b11;
    rd(6'h08, 2'b10, d, r);
    check_eq("stall done clr", {30'h0, d[1:0]}, 32'h0);

    // Writes during busy must not disturb the operation
    v = 32'h9ABCDEF0; m = 32'h0FF00FF0;
    set_vm(v, m, 1'b0);
    start(1'b0);
    wr(6'h00, 32'h0, 2'b10);
    wr(6'h04, 32'h0, 2'b10);
    wr(6'h08, 32'h1, 2'b10);
    wait_idle(n);
    check_eq("prot busy cycles", n, 29);
    verify("prot", 1'b0, ref_select(v, m), 6'($countones(m)));
    start(1'b0);
    wait_idle(n);
    verify("prot again", 1'b0, ref_select(v, m), 6'($countones(m)));

    // Randomized operations
    for (int t = 0; t < 12; t++) begin
      v = $urandom;
      m = $urandom;
      if (t == 3) m = 32'h0;
      if (t == 7) m = 32'hFFFFFFFF;
      run_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), v, m,
             1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-operation
    set_vm(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    start(1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    address = 6'h08; data_read_n = 2'b10;
    #1;
    check_eq("rst status", data_out, 32'h0);
    address = 6'h0C;
    #1;
    check_eq("rst ready", {31'h0, data_ready}, 32'h1);
    check_eq("rst result", data_out, 32'h0);
    check_eq("rst uo_out", {24'h0, uo_out}, 32'h0);
    data_read_n = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(1'b1);
    wait_idle(n);
    verify("post rst value", 1'b1, 32'h0, 6'd0);
    start(1'b0);
    wait_idle(n);
    verify("post rst mask", 1'b0, 32'h0, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
